frontend_linebuf_writer: RTL and testbench

//  Consumes the captured, CSC'd pixel stream of the ISL51002 frontend and writes a cropped window of it

---
 rtl/frontend_linebuf_writer.sv | 170 +++++++++++++++++
 tb/tb_frontend_linebuf_writer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_linebuf_writer.sv
// Writes a cropped window of the frontend pixel stream into a ring of line-buffer slots,
// reporting frame starts, completed lines and slot occupancy to the downstream scaler.
module frontend_linebuf_writer #(
  parameter int NUM_LINES = 4,
  parameter int SLOT_W    = 2,
  parameter int X_W       = 11
) (
  input  logic                    PCLK_i,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              R_i,
  input  logic [7:0]              G_i,
  input  logic [7:0]              B_i,
  input  logic                    DE_i,
  input  logic                    VSYNC_i,
  input  logic                    FID_i,
  input  logic [10:0]             xpos_i,
  input  logic [10:0]             ypos_i,
  input  logic [10:0]             x_start,
  input  logic [10:0]             x_size,
  input  logic                    rd_release_i,
  output logic                    lb_we_o,
  output logic [SLOT_W+X_W-1:0]   lb_waddr_o,
  output logic [23:0]             lb_wdata_o,
  output logic                    frame_start_o,
  output logic                    frame_fid_o,
  output logic [SLOT_W-1:0]       frame_slot_o,
  output logic                    line_done_o,
  output logic [SLOT_W-1:0]       line_slot_o,
  output logic [10:0]             line_ypos_o,
  output logic [11:0]             line_pixels_o,
  output logic [SLOT_W:0]         fill_level_o,
  output logic                    drop_o,
  output logic [1:0]              dbg_state_o
);

  // Handshake: rd_release_i is a single-cycle pulse with no ready; each pulse frees the
  // oldest filled slot. line_done_o / frame_start_o are single-cycle pulses, no back-pressure.

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_LINE_WAIT  = 2'd2,
    S_LINE_ACT   = 2'd3
  } state_t;

  state_t              state;
  logic                de_q;
  logic                vs_q;
  logic                line_ok;
  logic [11:0]         pix_cnt;
  logic [10:0]         line_y;
  logic [SLOT_W-1:0]   wr_slot;

  logic                de_rise, de_fall, vs_fall;
  logic                frame_evt, line_start, line_active, line_end;
  logic                accept, in_range, wr_now;
  logic [11:0]         x_ext, lo_ext, hi_ext;
  logic [SLOT_W+1:0]   occupied;

  assign dbg_state_o = state;

  assign de_rise = DE_i & ~de_q;
  assign de_fall = ~DE_i & de_q;
  assign vs_fall = ~VSYNC_i & vs_q;

  assign x_ext    = {1'b0, xpos_i};
  assign lo_ext   = {1'b0, x_start};
  assign hi_ext   = {1'b0, x_start} + {1'b0, x_size};
  assign in_range = (x_ext >= lo_ext) && (x_ext < hi_ext);

  // fill_level_o counts a completed line one cycle after its line_done_o pulse, so the
  // pending pulse is included when deciding whether a new line still has a free slot.
  assign occupied = {1'b0, fill_level_o} + {{(SLOT_W+1){1'b0}}, line_done_o};
  assign accept   = occupied < (SLOT_W+2)'(NUM_LINES);

  assign frame_evt   = enable && vs_fall && (state != S_IDLE);
  assign line_start  = enable && (state == S_LINE_WAIT) && de_rise && !vs_fall;
  assign line_active = (state == S_LINE_ACT) && line_ok;
  assign line_end    = enable && line_active && (de_fall || vs_fall);
  assign wr_now      = enable && DE_i && in_range && !vs_fall &&
                       ((line_start && accept) || line_active);

  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      de_q          <= 1'b0;
      vs_q          <= 1'b0;
      line_ok       <= 1'b0;
      pix_cnt       <= '0;
      line_y        <= '0;
      wr_slot       <= '0;
      lb_we_o       <= 1'b0;
      lb_waddr_o    <= '0;
      lb_wdata_o    <= '0;
      frame_start_o <= 1'b0;
      frame_fid_o   <= 1'b0;
      frame_slot_o  <= '0;
      line_done_o   <= 1'b0;
      line_slot_o   <= '0;
      line_ypos_o   <= '0;
      line_pixels_o <= '0;
      fill_level_o  <= '0;
      drop_o        <= 1'b0;
    end else begin
      de_q          <= DE_i;
      vs_q          <= VSYNC_i;
      lb_we_o       <= wr_now;
      frame_start_o <= frame_evt;
      line_done_o   <= line_end;

      if (wr_now) begin
        lb_waddr_o <= {wr_slot, X_W'(xpos_i - x_start)};
        lb_wdata_o <= {R_i, G_i, B_i};
      end

      if (line_done_o && !rd_release_i)
        fill_level_o <= fill_level_o + 1'b1;
      else if (!line_done_o && rd_release_i && (fill_level_o != '0))
        fill_level_o <= fill_level_o - 1'b1;

      if (!enable) begin
        state   <= S_IDLE;
        line_ok <= 1'b0;
        drop_o  <= 1'b0;
      end else begin
        case (state)
          S_IDLE:       state <= S_WAIT_FRAME;
          S_WAIT_FRAME: if (vs_fall) state <= S_LINE_WAIT;
          S_LINE_WAIT: begin
            if (line_start) begin
              state   <= S_LINE_ACT;
              line_ok <= accept;
              if (accept) begin
                line_y  <= ypos_i;
                pix_cnt <= {11'd0, wr_now};
              end else begin
                drop_o <= 1'b1;
              end
            end
          end
          S_LINE_ACT: begin
            if (vs_fall || de_fall) begin
              state   <= S_LINE_WAIT;
              line_ok <= 1'b0;
            end else if (wr_now && (pix_cnt != 12'hfff)) begin
              pix_cnt <= pix_cnt + 12'd1;
            end
          end
          default: state <= S_IDLE;
        endcase

        if (line_end) begin
          line_slot_o   <= wr_slot;
          line_ypos_o   <= line_y;
          line_pixels_o <= pix_cnt;
          wr_slot       <= wr_slot + 1'b1;
        end

        // A vsync that cuts a line short closes it first, so the new frame begins in the next slot.
        if (frame_evt) begin
          frame_fid_o  <= FID_i;
          frame_slot_o <= line_end ? wr_slot + 1'b1 : wr_slot;
          drop_o       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frontend_linebuf_writer.sv
// Randomized scoreboard bench for frontend_linebuf_writer: a line-level reference model
// pushes expected writes, line completions and frame starts; a negedge monitor pops them.
module tb_frontend_linebuf_writer;

  localparam int NUM = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  r_in, g_in, b_in;
  logic        de, vsync, fid;
  logic [10:0] xpos, ypos, x_start, x_size;
  logic        rd_release;
  logic        lb_we_o;
  logic [12:0] lb_waddr_o;
  logic [23:0] lb_wdata_o;
  logic        frame_start_o, frame_fid_o;
  logic [1:0]  frame_slot_o;
  logic        line_done_o;
  logic [1:0]  line_slot_o;
  logic [10:0] line_ypos_o;
  logic [11:0] line_pixels_o;
  logic [2:0]  fill_level_o;
  logic        drop_o;
  logic [1:0]  dbg_state_o;

  frontend_linebuf_writer dut (
    .PCLK_i(clk), .reset(rst), .enable(enable),
    .R_i(r_in), .G_i(g_in), .B_i(b_in),
    .DE_i(de), .VSYNC_i(vsync), .FID_i(fid),
    .xpos_i(xpos), .ypos_i(ypos), .x_start(x_start), .x_size(x_size),
    .rd_release_i(rd_release),
    .lb_we_o(lb_we_o), .lb_waddr_o(lb_waddr_o), .lb_wdata_o(lb_wdata_o),
    .frame_start_o(frame_start_o), .frame_fid_o(frame_fid_o), .frame_slot_o(frame_slot_o),
    .line_done_o(line_done_o), .line_slot_o(line_slot_o), .line_ypos_o(line_ypos_o),
    .line_pixels_o(line_pixels_o), .fill_level_o(fill_level_o), .drop_o(drop_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [36:0] exp_wr_q[$];
  logic [24:0] exp_done_q[$];
  logic [2:0]  exp_frm_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_wr_seen = 0;
  int n_wr_exp  = 0;

  // reference model state
  int m_slot = 0;
  int m_fill = 0;
  bit m_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  logic [36:0] e_wr;
  logic [24:0] e_done;
  logic [2:0]  e_frm;
  always @(negedge clk) begin
    if (!rst) begin
      if (lb_we_o) begin
        n_wr_seen++;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'(lb_we_o), 64'd0);
        else begin
          e_wr = exp_wr_q.pop_front();
          chk("wr_addr_data", 64'({lb_waddr_o, lb_wdata_o}), 64'(e_wr));
        end
      end
      if (line_done_o) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 64'(line_done_o), 64'd0);
        else begin
          e_done = exp_done_q.pop_front();
          chk("line_done", 64'({line_slot_o, line_ypos_o, line_pixels_o}), 64'(e_done));
        end
      end
      if (frame_start_o) begin
        if (exp_frm_q.size() == 0) chk("frame_unexpected", 64'(frame_start_o), 64'd0);
        else begin
          e_frm = exp_frm_q.pop_front();
          chk("frame_start", 64'({frame_fid_o, frame_slot_o}), 64'(e_frm));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, "_fill"}, 64'(fill_level_o), 64'(m_fill));
    chk({tag, "_drop"}, 64'(drop_o), 64'(m_drop));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 64'(lb_we_o), 64'd0);
    chk({tag, "_waddr"}, 64'(lb_waddr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(lb_wdata_o), 64'd0);
    chk({tag, "_fstart"}, 64'(frame_start_o), 64'd0);
    chk({tag, "_ffid"}, 64'(frame_fid_o), 64'd0);
    chk({tag, "_fslot"}, 64'(frame_slot_o), 64'd0);
    chk({tag, "_ldone"}, 64'(line_done_o), 64'd0);
    chk({tag, "_lslot"}, 64'(line_slot_o), 64'd0);
    chk({tag, "_lypos"}, 64'(line_ypos_o), 64'd0);
    chk({tag, "_lpix"}, 64'(line_pixels_o), 64'd0);
    chk({tag, "_fill"}, 64'(fill_level_o), 64'd0);
    chk({tag, "_drop"}, 64'(drop_o), 64'd0);
  endtask

  function automatic bit model_in_range(input int x);
    return (x >= int'(x_start)) && (x < int'(x_start) + int'(x_size));
  endfunction

  task automatic push_pixel(input int x, input bit acc, inout int cnt);
    r_in = 8'($urandom_range(0, 255));
    g_in = 8'($urandom_range(0, 255));
    b_in = 8'($urandom_range(0, 255));
    if (acc && model_in_range(x)) begin
      exp_wr_q.push_back({2'(m_slot), 11'(x - int'(x_start)), r_in, g_in, b_in});
      n_wr_exp++;
      cnt++;
    end
  endtask

  task automatic drive_line(input int x0, input int n, input int y, input bit live,
                            input bit rel_at_done);
    bit acc;
    int cnt;
    cnt = 0;
    acc = live && (m_fill < NUM);
    for (int i = 0; i < n; i++) begin
      tick();
      de = 1'b1;
      xpos = 11'(x0 + i);
      ypos = 11'(y);
      push_pixel(x0 + i, acc, cnt);
    end
    tick();
    de = 1'b0;
    if (live) begin
      if (acc) begin
        exp_done_q.push_back({2'(m_slot), 11'(y), 12'(cnt)});
        m_slot = (m_slot + 1) % NUM;
        if (!rel_at_done) m_fill++;
      end else begin
        m_drop = 1'b1;
      end
    end
    if (rel_at_done) begin
      tick();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic do_frame(input bit f);
    tick();
    vsync = 1'b0;
    fid = f;
    exp_frm_q.push_back({f, 2'(m_slot)});
    m_drop = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic release_slot();
    tick();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    if (m_fill > 0) m_fill--;
    tick();
  endtask

  // stimulus
  initial begin
    int cnt;
    rst = 1'b1; enable = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    de = 1'b0; vsync = 1'b1; fid = 1'b0;
    xpos = '0; ypos = '0; x_start = 11'd10; x_size = 11'd4;
    rd_release = 1'b0;
    #12;
    check_all_zero("reset");
    chk("reset_state", 64'(dbg_state_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // DE activity before the first vsync must not write
    enable = 1'b1;
    repeat (2) tick();
    drive_line(0, 20, 3, 1'b0, 1'b0);
    drive_line(0, 12, 4, 1'b0, 1'b0);

    // cropped line
    do_frame(1'b0);
    drive_line(0, 20, 5, 1'b1, 1'b0);
    check_status("line1");
    release_slot();
    release_slot();
    check_status("release_at_zero");

    // overflow: five lines with no consumer
    for (int l = 0; l < 5; l++) begin
      x_start = 11'($urandom_range(0, 15));
      x_size  = 11'($urandom_range(0, 12));
      drive_line(0, $urandom_range(1, 30), $urandom_range(0, 2047), 1'b1, 1'b0);
    end
    check_status("overflow");
    do_frame(1'($urandom_range(0, 1)));
    check_status("drop_cleared");

    // release coincident with line_done
    release_slot();
    release_slot();
    x_start = 11'd10; x_size = 11'd4;
    drive_line(0, 20, 77, 1'b1, 1'b1);
    check_status("release_with_done");

    // vsync cutting a line after 7 written pixels
    x_start = 11'd0; x_size = 11'd100;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      de = 1'b1; xpos = 11'(i); ypos = 11'd300;
      push_pixel(i, 1'b1, cnt);
    end
    tick();
    vsync = 1'b0; fid = 1'b1; xpos = 11'd7;
    exp_done_q.push_back({2'(m_slot), 11'd300, 12'(cnt)});
    m_slot = (m_slot + 1) % NUM;
    m_fill++;
    exp_frm_q.push_back({1'b1, 2'(m_slot)});
    m_drop = 1'b0;
    tick();
    de = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (3) tick();
    check_status("partial_line");

    // empty window and window clipped at the right edge
    repeat (3) release_slot();
    x_start = 11'd40; x_size = 11'd0;
    drive_line(30, 20, 11, 1'b1, 1'b0);
    x_start = 11'd2040; x_size = 11'd100;
    drive_line(2030, 18, 12, 1'b1, 1'b0);
    check_status("edge_windows");

    // enable dropped mid-line
    repeat (2) release_slot();
    drive_line(0, 5, 20, 1'b1, 1'b0);
    x_start = 11'd0; x_size = 11'd50;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      de = 1'b1; xpos = 11'(i); ypos = 11'd21;
      push_pixel(i, 1'b1, cnt);
    end
    tick();
    enable = 1'b0; xpos = 11'd3;
    tick();
    de = 1'b0;
    m_drop = 1'b0;
    repeat (3) tick();
    check_status("disabled");
    enable = 1'b1;
    repeat (2) tick();
    do_frame(1'b0);
    drive_line(0, 10, 22, 1'b1, 1'b0);
    check_status("reenabled");

    // asynchronous reset mid-line
    for (int i = 0; i < 3; i++) begin
      tick();
      de = 1'b1; xpos = 11'(i); ypos = 11'd9;
      push_pixel(i, 1'b1, cnt);
    end
    tick();
    xpos = 11'd3;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midline_reset");
    de = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_slot = 0; m_fill = 0; m_drop = 1'b0;
    release_slot();
    check_status("after_reset");
    repeat (2) tick();
    do_frame(1'b1);
    drive_line(0, 8, 33, 1'b1, 1'b0);

    // randomized frames
    for (int f = 0; f < 3; f++) begin
      do_frame(1'($urandom_range(0, 1)));
      for (int l = 0; l < 6; l++) begin
        x_start = 11'($urandom_range(0, 20));
        x_size  = 11'($urandom_range(0, 15));
        drive_line($urandom_range(0, 1000), $urandom_range(1, 40),
                   $urandom_range(0, 2047), 1'b1, 1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) release_slot();
        check_status("random");
      end
    end

    repeat (5) tick();
    chk("wr_q_left", 64'(exp_wr_q.size()), 64'd0);
    chk("done_q_left", 64'(exp_done_q.size()), 64'd0);
    chk("frame_q_left", 64'(exp_frm_q.size()), 64'd0);
    chk("wr_count", 64'(n_wr_seen), 64'(n_wr_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
